// File: rtl/disp_scroller.sv
// disp_scroller: scrolling multi-digit seven-segment driver.
// Latches a bitmap buffer on start, scans it across DIGITS common-anode
// digits (one digit per MUX_DIV cycles) and advances the visible window one
// character every SCROLL_DIV cycles, wrapping circularly.
// Optional feature macro: DISP_SCROLL_GAP_EN -- inserts a full screen of
// blanks between repeats so text enters from the right onto an empty display.

// Per-digit character resolver: maps window position + lane to a buffer
// index modulo the scroll period and fetches that character (or blank).
module disp_scroller_lane #(
  parameter int CHARS  = 64,
  parameter int DIGITS = 4,
  parameter int LANE   = 0,
  parameter int PW     = 8
) (
  input  logic [PW-1:0]           pos,
  input  logic [PW-1:0]           per,
  input  logic [PW-1:0]           slen,
  input  logic [CHARS-1:0][6:0]   shadow,
  output logic [6:0]              seg
);

  logic [PW-1:0] idx;

  // pos < per and LANE < DIGITS, so DIGITS conditional subtractions always
  // reduce the sum into [0, per) even when per is shorter than the display.
  always_comb begin
    idx = pos + PW'(LANE);
    for (int i = 0; i < DIGITS; i++)
      if (idx >= per) idx = idx - per;
    seg = '0;
    if (idx < slen)
      for (int k = 0; k < CHARS; k++)
        if (idx == PW'(k)) seg = shadow[k];
  end

endmodule

module disp_scroller #(
  parameter int DIGITS     = 4,
  parameter int CHARS      = 64,
  parameter int SCROLL_DIV = 25_000_000,
  parameter int MUX_DIV    = 50_000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7*CHARS-1:0]         bitmap,
  input  logic [$clog2(CHARS):0]     len,
  input  logic                       start,
  input  logic                       pause,
  output logic [6:0]                 seg,
  output logic [DIGITS-1:0]          an,
  output logic                       busy,
  output logic                       wrapped
);

  localparam int LW = $clog2(CHARS) + 1;
  // holds CHARS + 2*DIGITS, comfortably above period + DIGITS - 1
  localparam int PW = $clog2(CHARS + 2*DIGITS + 1);
  localparam int MW = $clog2(MUX_DIV + 1);
  localparam int SW = $clog2(SCROLL_DIV + 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;

  state_t                  state, nstate;
  logic [PW-1:0]           pos, npos, d, nd;
  logic [MW-1:0]           mcnt, nmcnt;
  logic [SW-1:0]           scnt, nscnt;
  logic [CHARS-1:0][6:0]   shadow, nshadow;
  logic [LW-1:0]           slen, nslen, eff_len;
  logic                    nwrap, load, mtc, stc;
  logic [PW-1:0]           per_cur, nper, nslen_w;
  logic [DIGITS-1:0][6:0]  lane_seg;
  logic [6:0]              nseg;
  logic [DIGITS-1:0]       nan;

  function automatic logic [PW-1:0] period(input logic [LW-1:0] l);
`ifdef DISP_SCROLL_GAP_EN
    return PW'(l) + PW'(DIGITS);
`else
    return PW'(l);
`endif
  endfunction

  assign eff_len = (len > LW'(CHARS)) ? LW'(CHARS) : len;
  assign load    = start && (eff_len != '0);
  assign mtc     = (mcnt == MW'(MUX_DIV - 1));
  assign stc     = (scnt == SW'(SCROLL_DIV - 1));
  assign per_cur = period(slen);
  assign nper    = period(nslen);
  assign nslen_w = PW'(nslen);

  // Next-state: load on start, else scan always and scroll only while running.
  always_comb begin
    nstate  = state;
    npos    = pos;
    nd      = d;
    nmcnt   = mcnt;
    nscnt   = scnt;
    nshadow = shadow;
    nslen   = slen;
    nwrap   = 1'b0;
    if (load) begin
      nstate  = RUN;
      nshadow = bitmap;
      nslen   = eff_len;
      npos    = '0;
      nd      = '0;
      nmcnt   = '0;
      nscnt   = '0;
    end else if (state != IDLE) begin
      if (mtc) begin
        nmcnt = '0;
        nd    = (d == PW'(DIGITS - 1)) ? '0 : d + PW'(1);
      end else begin
        nmcnt = mcnt + MW'(1);
      end
      if (state == RUN) begin
        // pause seen this cycle freezes the scroll counter immediately
        if (pause) begin
          nstate = PAUSED;
        end else if (stc) begin
          nscnt = '0;
          if (pos == per_cur - PW'(1)) begin
            npos  = '0;
            nwrap = 1'b1;
          end else begin
            npos = pos + PW'(1);
          end
        end else begin
          nscnt = scnt + SW'(1);
        end
      end else if (!pause) begin
        nstate = RUN;
      end
    end
  end

  // Every digit's character is resolved from the next-state window so the
  // registered seg/an reflect a load on the very next cycle.
  for (genvar g = 0; g < DIGITS; g++) begin : g_lane
    disp_scroller_lane #(
      .CHARS (CHARS),
      .DIGITS(DIGITS),
      .LANE  (g),
      .PW    (PW)
    ) u_lane (
      .pos   (npos),
      .per   (nper),
      .slen  (nslen_w),
      .shadow(nshadow),
      .seg   (lane_seg[g])
    );
  end

  // Pick the scanned digit's character and its active-low enable.
  always_comb begin
    nseg = '0;
    nan  = '1;
    for (int g = 0; g < DIGITS; g++)
      if (nd == PW'(g)) begin
        nseg   = lane_seg[g];
        nan[g] = 1'b0;
      end
  end

  // State, counters, shadow buffer and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pos     <= '0;
      d       <= '0;
      mcnt    <= '0;
      scnt    <= '0;
      shadow  <= '0;
      slen    <= '0;
      seg     <= '0;
      an      <= '1;
      busy    <= 1'b0;
      wrapped <= 1'b0;
    end else begin
      state   <= nstate;
      pos     <= npos;
      d       <= nd;
      mcnt    <= nmcnt;
      scnt    <= nscnt;
      shadow  <= nshadow;
      slen    <= nslen;
      busy    <= (nstate != IDLE);
      wrapped <= nwrap;
      if (nstate == IDLE) begin
        seg <= '0;
        an  <= '1;
      end else begin
        seg <= nseg;
        an  <= nan;
      end
    end
  end

endmodule

// File: tb/tb_disp_scroller.sv
// Scoreboard bench for disp_scroller: stimulus queues expected outputs
// tagged with the cycle they are due; a negedge monitor compares them.
module tb_disp_scroller;

  localparam int DIGITS = 4;
  localparam int CHARS  = 8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [7*CHARS-1:0]   bitmap = '0;
  logic [3:0]           len = '0;
  logic                 start = 1'b0;
  logic                 pause = 1'b0;
  logic [6:0]           seg;
  logic [DIGITS-1:0]    an;
  logic                 busy, wrapped;

  int cyc = 0;
  int tests = 0;
  int failed = 0;

  typedef struct {
    int         cyc;
    string      nm;
    bit         cs, ca, cb, cw;
    logic [6:0] seg;
    logic [3:0] an;
    logic       busy;
    logic       wrapped;
  } exp_t;

  exp_t q[$];

  logic [6:0] txt [4];
  logic [3:0] ant [4];

  disp_scroller #(
    .DIGITS    (DIGITS),
    .CHARS     (CHARS),
    .SCROLL_DIV(8),
    .MUX_DIV   (2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bitmap (bitmap),
    .len    (len),
    .start  (start),
    .pause  (pause),
    .seg    (seg),
    .an     (an),
    .busy   (busy),
    .wrapped(wrapped)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push(int c, string nm, bit cs, bit ca, bit cb, bit cw,
                               logic [6:0] s, logic [3:0] a, logic b, logic w);
    exp_t e;
    e.cyc = c; e.nm = nm; e.cs = cs; e.ca = ca; e.cb = cb; e.cw = cw;
    e.seg = s; e.an = a; e.busy = b; e.wrapped = w;
    q.push_back(e);
  endfunction

  function automatic void exp_all(int c, string nm, logic [6:0] s, logic [3:0] a,
                                  logic b, logic w);
    push(c, nm, 1, 1, 1, 1, s, a, b, w);
  endfunction

  function automatic void exp_disp(int c, string nm, logic [3:0] a, logic [6:0] s);
    push(c, nm, 1, 1, 0, 0, s, a, 1'b0, 1'b0);
  endfunction

  function automatic void exp_wrap(int c, string nm, logic w);
    push(c, nm, 0, 0, 0, 1, 7'h0, 4'h0, 1'b0, w);
  endfunction

  function automatic logic [55:0] mk(input logic [6:0] c0, c1, c2, c3);
    return {28'h0, c3, c2, c1, c0};
  endfunction

  // monitor: compare every expectation due at this cycle
  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc <= cyc) begin
        tests++;
        if ((q[i].cs && seg !== q[i].seg) || (q[i].ca && an !== q[i].an) ||
            (q[i].cb && busy !== q[i].busy) || (q[i].cw && wrapped !== q[i].wrapped)) begin
          failed++;
          $display("FAIL %s @cyc %0d: got seg=%h an=%b busy=%b wrapped=%b, want seg=%h an=%b busy=%b wrapped=%b (checked s%0d a%0d b%0d w%0d)",
                   q[i].nm, cyc, seg, an, busy, wrapped, q[i].seg, q[i].an,
                   q[i].busy, q[i].wrapped, q[i].cs, q[i].ca, q[i].cb, q[i].cw);
        end
        q.delete(i);
      end
    end
  end

  // returns 1ns after edge n, so anything driven then is sampled at edge n+1
  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_go(input logic [55:0] bm, input logic [3:0] l, output int s);
    @(posedge clk);
    #1;
    bitmap = bm;
    len    = l;
    start  = 1'b1;
    s      = cyc + 1;
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (q.size() == 0) break;
      @(posedge clk);
    end
    if (q.size() != 0) begin
      tests++;
      failed++;
      $display("FAIL drain: %0d expectations still pending, want 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int wrap_at;
    int win;
    txt[0] = 7'h06; txt[1] = 7'h5B; txt[2] = 7'h4F; txt[3] = 7'h66;
    ant[0] = 4'b1110; ant[1] = 4'b1101; ant[2] = 4'b1011; ant[3] = 4'b0111;

    // reset
    exp_all(1, "reset1", 7'h0, 4'hF, 1'b0, 1'b0);
    exp_all(2, "reset2", 7'h0, 4'hF, 1'b0, 1'b0);
    wait_cyc(2);
    rst = 1'b0;

    // start with len = 0 is ignored
    start_go(mk(7'h06, 7'h5B, 7'h4F, 7'h66), 4'd0, s);
    exp_all(s, "len0", 7'h0, 4'hF, 1'b0, 1'b0);
    exp_all(s + 3, "len0_hold", 7'h0, 4'hF, 1'b0, 1'b0);
    wait_cyc(s);
    start = 1'b0;
    drain();

    // scan, scroll and wrap
    start_go(mk(7'h06, 7'h5B, 7'h4F, 7'h66), 4'd4, s);
    exp_all(s, "first_digit", 7'h06, 4'b1110, 1'b1, 1'b0);
    for (int k = 1; k < 8; k++)
      exp_disp(s + k, $sformatf("scan%0d", k), ant[k/2], txt[k/2]);
    exp_disp(s + 8, "scroll1_d0", 4'b1110, 7'h5B);
    exp_disp(s + 10, "scroll1_d1", 4'b1101, 7'h4F);
`ifdef DISP_SCROLL_GAP_EN
    wrap_at = 64;
    win     = 70;
    exp_disp(s + 14, "scroll1_d3", 4'b0111, 7'h00);
    exp_disp(s + 32, "gap_d0", 4'b1110, 7'h00);
    exp_disp(s + 34, "gap_d1", 4'b1101, 7'h00);
    exp_disp(s + 36, "gap_d2", 4'b1011, 7'h00);
    exp_disp(s + 38, "gap_d3", 4'b0111, 7'h00);
    exp_disp(s + 64, "wrap_d0", 4'b1110, 7'h06);
`else
    wrap_at = 32;
    win     = 40;
    exp_disp(s + 14, "scroll1_d3", 4'b0111, 7'h06);
    exp_disp(s + 32, "wrap_d0", 4'b1110, 7'h06);
    exp_disp(s + 34, "wrap_d1", 4'b1101, 7'h5B);
`endif
    exp_wrap(s, "wrap_on_start", 1'b0);
    for (int k = 1; k <= win; k++)
      exp_wrap(s + k, $sformatf("wrap%0d", k), (k == wrap_at) ? 1'b1 : 1'b0);
    wait_cyc(s);
    start = 1'b0;
    drain();

    // short text
    start_go(mk(7'h06, 7'h5B, 7'h4F, 7'h66), 4'd2, s);
    exp_disp(s, "short_d0", 4'b1110, 7'h06);
    exp_disp(s + 2, "short_d1", 4'b1101, 7'h5B);
`ifdef DISP_SCROLL_GAP_EN
    exp_disp(s + 4, "short_d2", 4'b1011, 7'h00);
    exp_disp(s + 6, "short_d3", 4'b0111, 7'h00);
`else
    exp_disp(s + 4, "short_d2", 4'b1011, 7'h06);
    exp_disp(s + 6, "short_d3", 4'b0111, 7'h5B);
`endif
    wait_cyc(s);
    start = 1'b0;
    drain();

    // pause: high at edges s+4..s+23, counter resumes at s+25, step at s+29
    start_go(mk(7'h06, 7'h5B, 7'h4F, 7'h66), 4'd4, s);
    exp_disp(s + 16, "pause_hold_d0", 4'b1110, 7'h06);
    exp_disp(s + 18, "pause_scan_d1", 4'b1101, 7'h5B);
    exp_all(s + 20, "pause_busy", 7'h4F, 4'b1011, 1'b1, 1'b0);
    exp_disp(s + 25, "resume_d0", 4'b1110, 7'h06);
    exp_disp(s + 28, "pre_step", 4'b1011, 7'h4F);
    exp_disp(s + 29, "step", 4'b1011, 7'h66);
    exp_disp(s + 32, "after_step", 4'b1110, 7'h5B);
    wait_cyc(s);
    start = 1'b0;
    wait_cyc(s + 3);
    pause = 1'b1;
    wait_cyc(s + 23);
    pause = 1'b0;
    drain();

    // restart while paused, then reset mid-run
    @(posedge clk);
    #1;
    pause = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    start_go(mk(7'h7F, 7'h6D, 7'h07, 7'h39), 4'd4, s);
    exp_all(s, "restart_d0", 7'h7F, 4'b1110, 1'b1, 1'b0);
    exp_disp(s + 2, "restart_d1", 4'b1101, 7'h6D);
    exp_disp(s + 8, "restart_paused_d0", 4'b1110, 7'h7F);
    wait_cyc(s);
    start = 1'b0;
    wait_cyc(s + 12);
    pause = 1'b0;
    wait_cyc(s + 14);
    rst = 1'b1;
    exp_all(s + 15, "rst_mid", 7'h0, 4'hF, 1'b0, 1'b0);
    wait_cyc(s + 15);
    rst = 1'b0;
    exp_all(s + 18, "rst_idle", 7'h0, 4'hF, 1'b0, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/disp_scroller.md
# disp_scroller

Scrolling multi-digit seven-segment driver. Latches a packed buffer of 7-bit character bitmaps, time-multiplexes it across `DIGITS` common-anode digits and advances the visible window one character per scroll period, wrapping circularly. It sits between the character/keyboard logic that builds bitmap buffers and the board's segment/anode pins. It replaces static per-digit bitmap extraction.

## Interface
- `DIGITS`, 4: number of physical digits; digit 0 is leftmost.
- `CHARS`, 64: buffer capacity in characters. Buffer width is `7*CHARS`.
- `SCROLL_DIV`, 25_000_000: clock cycles per scroll step; must be ≥ 2.
- `MUX_DIV`, 50_000: clock cycles per digit in the refresh scan; must be ≥ 1.
- `clk` in 1: sole clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `bitmap` in `7*CHARS`: character k occupies bits `[7k+6:7k]`, counted from the LSB. Within a character, bit 6 is segment g and bit 0 is segment a.
- `len` in `$clog2(CHARS)+1`: number of valid characters.
- `start` in 1: single-cycle pulse that latches `bitmap`/`len` and starts scrolling.
- `pause` in 1: level. While high in RUN, scrolling freezes.
- `seg` out 7: segment bitmap for the selected digit, active-high.
- `an` out `DIGITS`: digit enables, active-low, one-hot-zero.
- `busy` out 1: high in RUN or PAUSED.
- `wrapped` out 1: one-cycle pulse when the window returns to position 0.

## Operation
- States:
  - IDLE: reset state. `an` = all ones, `seg` = 0.
  - RUN: scrolling.
  - PAUSED: scroll frozen, display still refreshed.
- On `start` with effective length `L` = min(`len`, `CHARS`) > 0:
  - copy `bitmap` to the shadow buffer and `L` to the shadow length;
  - set `pos` = 0; clear both counters;
  - go to RUN.
- `start` with `L` = 0 is ignored; the state is unchanged.
- `start` in RUN or PAUSED restarts the same way (re-latch, `pos` = 0, go to RUN).
- `start` has priority over `pause`.
- Pause transitions:
  - RUN → PAUSED when `pause` = 1.
  - PAUSED → RUN when `pause` = 0.
  - The scroll counter holds its value while PAUSED.
- Scan:
  - The mux counter counts 0..`MUX_DIV-1` in RUN and PAUSED.
  - At terminal count, digit index `d` advances modulo `DIGITS`.
- Digit `d` displays the character at index `(pos+d) mod P` of the shadow buffer. `P` is the scroll period length (see Configuration).
  - Indices ≥ shadow length display blank (`seg` = 0).
- Scroll counter:
  - Counts 0..`SCROLL_DIV-1` in RUN only.
  - At terminal count, `pos` ← `pos+1`, or 0 if `pos` = `P-1`.
  - When `pos` wraps to 0, `wrapped` pulses for that cycle.
- No arithmetic overflow: `pos`, `d` and the summed index are sized to hold `P + DIGITS - 1`.
- Reset mid-operation: on the next edge, return to IDLE with all outputs at reset values. The shadow buffer is cleared.

## Timing
- Reset values: `seg` = 0, `an` = all ones, `busy` = 0, `wrapped` = 0.
- `seg` and `an` are registered and change together in the same cycle.
- The first digit is driven one cycle after the `start` edge: `an` = ~1 (digit 0 enabled), `seg` = char 0.
- `busy` rises in the cycle after `start`.
- In RUN, `pos` advances every `SCROLL_DIV` cycles after `start`. The first step occurs `SCROLL_DIV` cycles after the `start` edge.
- `wrapped` is asserted in the same cycle `pos` becomes 0. It never asserts on `start`.
- Pause latency: `pause` sampled high stops the next scroll step. No step occurs on the cycle `pause` is first seen.

## Configuration
- `DISP_SCROLL_GAP_EN` defined:
  - `P` = shadow length + `DIGITS`.
  - A full screen of blanks scrolls through between repeats, so text enters from the right onto an empty display.
- Macro undefined:
  - `P` = shadow length.
  - Text wraps seamlessly: the last character is followed directly by the first.

## Test plan
Bench parameters: `DIGITS`=4, `CHARS`=8, `SCROLL_DIV`=8, `MUX_DIV`=2; macro undefined unless stated.
- Reset: after `rst` high for 2 cycles, `seg`=0, `an`=4'b1111, `busy`=0, `wrapped`=0. `start` with `len`=0 leaves `busy`=0.
- Scan: buffer chars 0..3 = 7'h06, 7'h5B, 7'h4F, 7'h66, `len`=4, `start`. Required `an` sequence 1110, 1101, 1011, 0111, each held 2 cycles, with `seg` 06, 5B, 4F, 66 respectively.
- Scroll/wrap: same setup. After 8 cycles digit 0 shows 5B. `wrapped` pulses exactly once, 32 cycles after `start`. Repeat with `DISP_SCROLL_GAP_EN`: first wrap at 64 cycles, and at `pos`=4 all digits show `seg`=0.
- Short text: `len`=2 (chars 06, 5B) without the gap. Digits 0..3 show 06, 5B, 06, 5B.
- Pause: hold `pause` for 20 cycles mid-run. `pos` is unchanged and the scan continues. After release, the next step comes after the remaining scroll count.
- Restart and reset: `start` with a new buffer while PAUSED gives `pos`=0 and the new char 0 on digit 0 next cycle. `rst` mid-run gives the reset values on the next edge.
